dcache_ctrl: RTL
================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter SETS, default 16, number of direct-mapped one-word lines (power of two).
REQ-002 Parameter ADDR_W, default 30, word-address width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  memory-stage access valid.
REQ-006 cpu_we  input  1  1 = store, 0 = load.
REQ-007 cpu_addr  input  ADDR_W  word address (byte address [31:2]).
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_rdata  output  32  load data, valid when cpu_req & ~cpu_we & ~cpu_stall.
REQ-010 cpu_stall  output  1  freeze fetch/decode/mem pipes this cycle.
REQ-011 hit  output  1  one-cycle pulse on a read hit in IDLE.
REQ-012 mem_req  output  1  backing-memory request, held until mem_ack.
REQ-013 mem_we  output  1  backing request is a write.
REQ-014 mem_addr  output  ADDR_W  backing word address.
REQ-015 mem_wdata  output  32  backing write data.
REQ-016 mem_ack  input  1  backing request complete this cycle; variable latency of at least 1 cycle.
REQ-017 mem_rdata  input  32  refill data, valid with mem_ack on reads.

Function
REQ-018 Address split: index = cpu_addr[log2(SETS)-1:0]; tag = remaining upper bits.
REQ-019 Policy: write-through, no-write-allocate.
REQ-020 States: IDLE, RD_MISS, WR_BUSY, DONE.
REQ-021 IDLE, read, valid & tag match: cpu_rdata = line data combinationally; cpu_stall = 0; hit = 1; stay IDLE.
REQ-022 IDLE, read miss: cpu_stall = 1 in the same cycle; latch addr; go RD_MISS.
REQ-023 IDLE, write: cpu_stall = 1; latch addr and data; go WR_BUSY.
REQ-024 IDLE, cpu_req = 0: no stall, no memory activity.
REQ-025 RD_MISS: mem_req = 1, mem_we = 0, mem_addr = latched addr; cpu_stall = 1.
REQ-026 RD_MISS with mem_ack: write line (valid = 1, tag, mem_rdata); capture mem_rdata; go DONE.
REQ-027 WR_BUSY: mem_req = 1, mem_we = 1, latched addr and data; cpu_stall = 1.
REQ-028 WR_BUSY with mem_ack: update line data only if valid & tag match (otherwise leave line untouched); go DONE.
REQ-029 DONE: cpu_stall = 0; cpu_rdata = captured data; the held request is retired, not looked up again; go IDLE unconditionally.
REQ-030 Latency:
  - read hit: 0 extra cycles;
  - miss or write: stall for (cycles to mem_ack) + 1, then the DONE cycle with stall = 0.
REQ-031 mem_req, mem_we, mem_addr and mem_wdata are stable from the first request cycle through the mem_ack cycle.
REQ-032 mem_ack outside RD_MISS/WR_BUSY is ignored.
REQ-033 cpu_req dropping during RD_MISS/WR_BUSY does not abort the transaction; it completes to DONE.
REQ-034 hit = 0 in every state other than IDLE.
REQ-035 Conflicting index (different tag) replaces the line on a read refill only.

Reset
REQ-036 rst low, asynchronously:
  - state = IDLE;
  - all valid bits = 0;
  - mem_req = 0, mem_we = 0, cpu_stall = 0, hit = 0;
  - cpu_rdata, mem_addr, mem_wdata = 0.
REQ-037 Reset during RD_MISS/WR_BUSY abandons the request: mem_req = 0 from reset assertion, and no line is written.
REQ-038 Tag and data arrays need no reset; only valid bits are cleared.

Structure
REQ-039 Package dcache_pkg holds:
  - state enum dcache_state_t;
  - SETS_DEF, INDEX_W, TAG_W localparams.
REQ-040 One sub-module, dcache_array: valid/tag/data storage, one combinational read port, one synchronous write port, async-clear of valid bits.
REQ-041 FSM and request latches live in dcache_ctrl.

Verification
REQ-042 Cold read 0x10, mem_ack after 3 cycles with 0xDEADBEEF:
  - stall high for 4 cycles; DONE rdata = 0xDEADBEEF;
  - re-read 0x10: hit = 1, no stall, rdata = 0xDEADBEEF.
REQ-043 Write 0x10 = 0x12345678 after REQ-042 fill:
  - mem_we = 1, mem_wdata = 0x12345678, held until ack;
  - re-read 0x10 hits with 0x12345678.
REQ-044 Write 0x20 on a cold cache:
  - write completes;
  - read 0x20 misses, showing no allocation.
REQ-045 Read 0x10, then read 0x00 (same index, different tag):
  - second read misses;
  - re-read 0x10 misses again, showing eviction.
REQ-046 Assert rst during RD_MISS:
  - mem_req falls immediately; state = IDLE;
  - a later read of the same address misses.
REQ-047 Spurious mem_ack in IDLE with cpu_req = 0: no state change, no line written, stall stays 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and default sizes
// for the direct-mapped write-through data cache.
package dcache_pkg;
  localparam int SETS_DEF   = 16;
  localparam int ADDR_W_DEF = 30;
  localparam int INDEX_W    = $clog2(SETS_DEF);
  localparam int TAG_W      = ADDR_W_DEF - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_BUSY,
    DONE
  } dcache_state_t;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU memory-stage side and backing
// memory side of the data cache in one bundle.
interface dcache_if
  import dcache_pkg::*;
  #(parameter int ADDR_W = ADDR_W_DEF);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_ack, mem_rdata,
    input  cpu_rdata, cpu_stall, hit,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_ack, mem_rdata,
    output cpu_rdata, cpu_stall, hit,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage, one async
// read port, one sync write port, valid cleared on reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS = SETS_DEF,
  parameter int IW   = INDEX_W,
  parameter int TW   = TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] ridx_i,
  output logic          rvalid_o,
  output logic [TW-1:0] rtag_o,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [TW-1:0] wtag_i,
  input  logic [31:0]   wdata_i
);
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  // Valid bits: the only storage that needs a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else if (we_i) valid_q[widx_i] <= 1'b1;
  end

  // Tag and data arrays are plain write-enabled storage.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-through, no-write-allocate
// direct-mapped data cache with a blocking miss FSM.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int SETS   = SETS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic     clk,
  input logic     rst,
  dcache_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW;

  dcache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] look_addr;
  logic              line_v;
  logic [TW-1:0]     line_tag;
  logic [31:0]       line_data;
  logic              match;
  logic              arr_we;
  logic [31:0]       arr_wdata;
  logic              stall, hit, mreq, mwe;
  logic [31:0]       rdata;

  // Outside IDLE the array is looked up with the held request.
  assign look_addr = (state_q == IDLE) ? bus.cpu_addr : addr_q;
  assign match = line_v && (line_tag == look_addr[ADDR_W-1:IW]);

  dcache_array #(
    .SETS(SETS),
    .IW  (IW),
    .TW  (TW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .ridx_i  (look_addr[IW-1:0]),
    .rvalid_o(line_v),
    .rtag_o  (line_tag),
    .rdata_o (line_data),
    .we_i    (arr_we),
    .widx_i  (addr_q[IW-1:0]),
    .wtag_i  (addr_q[ADDR_W-1:IW]),
    .wdata_i (arr_wdata)
  );

  // Next state, request latches and all outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    stall     = 1'b0;
    hit       = 1'b0;
    mreq      = 1'b0;
    mwe       = 1'b0;
    rdata     = '0;
    arr_we    = 1'b0;
    arr_wdata = line_data;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (!bus.cpu_we && match) begin
            hit   = 1'b1;
            rdata = line_data;
          end else begin
            stall   = 1'b1;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            state_d = bus.cpu_we ? WR_BUSY : RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        mreq  = 1'b1;
        if (bus.mem_ack) begin
          arr_we    = 1'b1;
          arr_wdata = bus.mem_rdata;
          rdata_d   = bus.mem_rdata;
          state_d   = DONE;
        end
      end
      WR_BUSY: begin
        stall = 1'b1;
        mreq  = 1'b1;
        mwe   = 1'b1;
        if (bus.mem_ack) begin
          arr_we    = match;
          arr_wdata = wdata_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        rdata   = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request latches, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset holds the pipeline free even with a request pending.
  assign bus.cpu_stall = stall & rst;
  assign bus.hit       = hit & rst;
  assign bus.cpu_rdata = rdata;
  assign bus.mem_req   = mreq;
  assign bus.mem_we    = mwe;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule
